// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response channels between the memory-stage initiator and the data RAM responder.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data RAM with fixed access latency and byte-strobed writes over valid/ready channels.
// Optional DMEM_MISALIGN_ERR_EN flags misaligned accesses with rsp_err and suppresses their effect.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input logic             clk,
   input logic             rst,
   dmem_responder_if.slave bus
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t         r_state;
   logic [3:0]     r_cnt;
   logic           r_we;
   logic [AW-1:0]  r_idx;
   logic [31:0]    r_wdata;
   logic [3:0]     r_wstrb;
   logic           r_mis;
   logic           r_valid;
   logic [31:0]    r_rdata;
   logic           r_err;
   logic [31:0]    r_mem [DEPTH_WORDS];
   logic           w_idle;
   logic           w_acc;
   logic           w_commit;
   logic           w_we;
   logic [AW-1:0]  w_idx;
   logic [31:0]    w_wdata;
   logic [3:0]     w_wstrb;
   logic           w_mis_in;
   logic           w_mis;
   logic           w_unused;
   assign w_idle   = r_state == IDLE;
   assign w_acc    = w_idle & bus.req_valid;
   // With LATENCY=1 the commit coincides with acceptance, so it uses the live request.
   assign w_commit = !rst & ((LATENCY == 1) ? w_acc : (r_state == WAIT && r_cnt == 4'd0));
   assign w_we     = w_idle ? bus.req_we : r_we;
   assign w_idx    = w_idle ? bus.req_addr[AW+1:2] : r_idx;
   assign w_wdata  = w_idle ? bus.req_wdata : r_wdata;
   assign w_wstrb  = w_idle ? bus.req_wstrb : r_wstrb;
   assign w_mis    = w_idle ? w_mis_in : r_mis;
`ifdef DMEM_MISALIGN_ERR_EN
   assign w_mis_in = |bus.req_addr[1:0];
`else
   assign w_mis_in = 1'b0;
`endif
   assign w_unused      = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};
   assign bus.req_ready = w_idle;
   assign bus.busy      = !w_idle;
   assign bus.rsp_valid = r_valid;
   assign bus.rsp_rdata = r_rdata;
   assign bus.rsp_err   = r_err;
   // RAM has no reset so contents survive it.
   always_ff @(posedge clk)
      if (w_commit & w_we & !w_mis)
         for (int i = 0; i < 4; i++)
            if (w_wstrb[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
   always_ff @(posedge clk)
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_valid <= 1'b0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         if (w_acc) begin
            r_we    <= bus.req_we;
            r_idx   <= bus.req_addr[AW+1:2];
            r_wdata <= bus.req_wdata;
            r_wstrb <= bus.req_wstrb;
            r_mis   <= w_mis_in;
         end
         case (r_state)
            IDLE: if (w_acc) begin
               r_state <= (LATENCY == 1) ? RESP : WAIT;
               r_cnt   <= 4'((LATENCY > 1) ? LATENCY - 2 : 0);
            end
            WAIT: if (r_cnt == 4'd0) r_state <= RESP;
                  else r_cnt <= r_cnt - 4'd1;
            RESP: if (bus.rsp_ready) begin
               r_state <= IDLE;
               r_valid <= 1'b0;
               r_rdata <= 32'd0;
               r_err   <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
         if (w_commit) begin
            r_valid <= 1'b1;
            r_rdata <= (w_we | w_mis) ? 32'd0 : r_mem[w_idx];
            r_err   <= w_mis;
         end
      end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on three responder configurations (L=2, L=4, DEPTH=4/L=1).
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid, req_we, rsp_ready, req_ready, rsp_valid, rsp_err, busy;
   logic [31:0] req_addr [3];
   logic [31:0] req_wdata [3];
   logic [3:0]  req_wstrb [3];
   logic [31:0] rsp_rdata [3];
   int          n_cmp = 0;
   int          n_bad = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder_if bus ();
      assign bus.req_valid = req_valid[g];
      assign bus.req_we    = req_we[g];
      assign bus.req_addr  = req_addr[g];
      assign bus.req_wdata = req_wdata[g];
      assign bus.req_wstrb = req_wstrb[g];
      assign bus.rsp_ready = rsp_ready[g];
      assign req_ready[g]  = bus.req_ready;
      assign rsp_valid[g]  = bus.rsp_valid;
      assign rsp_rdata[g]  = bus.rsp_rdata;
      assign rsp_err[g]    = bus.rsp_err;
      assign busy[g]       = bus.busy;
      dmem_responder #(
         .DEPTH_WORDS(g == 2 ? 4 : 1024),
         .LATENCY    (g == 0 ? 2 : (g == 1 ? 4 : 1))
      ) u_dut (.clk(clk), .rst(rst), .bus(bus));
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic xact(input int k, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic er, output int lat);
      req_valid[k] = 1'b1;
      req_we[k]    = we;
      req_addr[k]  = a;
      req_wdata[k] = d;
      req_wstrb[k] = s;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 1) begin
            req_valid[k] = 1'b0;
            req_we[k]    = ~we;
            req_addr[k]  = ~a;
            req_wdata[k] = ~d;
            req_wstrb[k] = 4'hF;
         end
      end while (!rsp_valid[k] && lat < 30);
      rd = rsp_rdata[k];
      er = rsp_err[k];
      tick();
   endtask
   task automatic wr(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int el, input logic ee, input string tag);
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(k, 1'b1, a, d, s, rd, er, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(el));
      chk({tag, "_rdata"}, rd, 32'd0);
      chk({tag, "_err"}, {31'd0, er}, {31'd0, ee});
   endtask
   task automatic rdc(input int k, input logic [31:0] a, input logic [31:0] ed, input logic ee,
                      input int el, input string tag);
      logic [31:0] rd;
      logic        er;
      int          lat;
      xact(k, 1'b0, a, 32'd0, 4'd0, rd, er, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(el));
      chk({tag, "_rdata"}, rd, ed);
      chk({tag, "_err"}, {31'd0, er}, {31'd0, ee});
   endtask
   initial begin
      int lat, acc, nv;
      logic seen;
      rst       = 1'b1;
      req_valid = '0;
      req_we    = '0;
      rsp_ready = 3'b111;
      for (int k = 0; k < 3; k++) begin
         req_addr[k]  = 32'd0;
         req_wdata[k] = 32'd0;
         req_wstrb[k] = 4'd0;
      end
      tick();
      tick();
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst%0d_req_ready", k), {31'd0, req_ready[k]}, 32'd1);
         chk($sformatf("rst%0d_rsp_valid", k), {31'd0, rsp_valid[k]}, 32'd0);
         chk($sformatf("rst%0d_rdata", k), rsp_rdata[k], 32'd0);
         chk($sformatf("rst%0d_err", k), {31'd0, rsp_err[k]}, 32'd0);
         chk($sformatf("rst%0d_busy", k), {31'd0, busy[k]}, 32'd0);
      end
      wr(0, 32'h10, 32'hDEADBEEF, 4'hF, 2, 1'b0, "wr_full");
      rdc(0, 32'h10, 32'hDEADBEEF, 1'b0, 2, "rd_full");
      wr(0, 32'h10, 32'h000000AA, 4'b0001, 2, 1'b0, "wr_b0");
      rdc(0, 32'h10, 32'hDEADBEAA, 1'b0, 2, "rd_b0");
      wr(0, 32'h10, 32'hFFFFFFFF, 4'b0000, 2, 1'b0, "wr_nostrb");
      rdc(0, 32'h10, 32'hDEADBEAA, 1'b0, 2, "rd_nostrb");
      wr(0, 32'h14, 32'h11223344, 4'hF, 2, 1'b0, "wr14_full");
      wr(0, 32'h14, 32'hAABBCCDD, 4'b1010, 2, 1'b0, "wr14_b13");
      rdc(0, 32'h14, 32'hAA22CC44, 1'b0, 2, "rd14_b13");
      rdc(0, 32'h1010, 32'hDEADBEAA, 1'b0, 2, "rd_wrap_a");
      rsp_ready[0] = 1'b0;
      req_valid[0] = 1'b1;
      req_we[0]    = 1'b0;
      req_addr[0]  = 32'h10;
      tick();
      req_valid[0] = 1'b0;
      lat = 1;
      while (!rsp_valid[0] && lat < 30) begin
         tick();
         lat++;
      end
      chk("bp_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d_valid", i), {31'd0, rsp_valid[0]}, 32'd1);
         chk($sformatf("bp%0d_rdata", i), rsp_rdata[0], 32'hDEADBEAA);
         chk($sformatf("bp%0d_req_ready", i), {31'd0, req_ready[0]}, 32'd0);
         chk($sformatf("bp%0d_busy", i), {31'd0, busy[0]}, 32'd1);
         tick();
      end
      rsp_ready[0] = 1'b1;
      tick();
      chk("bp_done_valid", {31'd0, rsp_valid[0]}, 32'd0);
      chk("bp_done_rdata", rsp_rdata[0], 32'd0);
      chk("bp_done_req_ready", {31'd0, req_ready[0]}, 32'd1);
      chk("bp_done_busy", {31'd0, busy[0]}, 32'd0);
      wr(1, 32'h20, 32'hCAFEF00D, 4'hF, 4, 1'b0, "b_wr");
      rdc(1, 32'h20, 32'hCAFEF00D, 1'b0, 4, "b_rd");
      req_valid[1] = 1'b1;
      req_we[1]    = 1'b1;
      req_addr[1]  = 32'h20;
      req_wdata[1] = 32'h12345678;
      req_wstrb[1] = 4'hF;
      tick();
      req_valid[1] = 1'b0;
      chk("b_wait_busy", {31'd0, busy[1]}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("b_rst_req_ready", {31'd0, req_ready[1]}, 32'd1);
      chk("b_rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
      chk("b_rst_busy", {31'd0, busy[1]}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rsp_valid[1]) seen = 1'b1;
         tick();
      end
      chk("b_no_rsp", {31'd0, seen}, 32'd0);
      rdc(1, 32'h20, 32'hCAFEF00D, 1'b0, 4, "b_rd_after_rst");
      rdc(0, 32'h10, 32'hDEADBEAA, 1'b0, 2, "a_persist");
      wr(2, 32'h00, 32'h00000011, 4'hF, 1, 1'b0, "c_wr");
      rdc(2, 32'h10, 32'h00000011, 1'b0, 1, "c_wrap");
      req_valid[2] = 1'b1;
      req_we[2]    = 1'b0;
      req_addr[2]  = 32'h0;
      acc = 0;
      nv  = 0;
      for (int i = 0; i < 10; i++) begin
         if (req_ready[2]) acc++;
         if (rsp_valid[2]) nv++;
         tick();
      end
      req_valid[2] = 1'b0;
      tick();
      tick();
      chk("c_accepts", 32'(acc), 32'd5);
      chk("c_responses", 32'(nv), 32'd5);
`ifdef DMEM_MISALIGN_ERR_EN
      rdc(0, 32'h13, 32'd0, 1'b1, 2, "mis_rd");
      wr(0, 32'h11, 32'h01020304, 4'hF, 2, 1'b1, "mis_wr");
      rdc(0, 32'h10, 32'hDEADBEAA, 1'b0, 2, "mis_unchanged");
`else
      rdc(0, 32'h13, 32'hDEADBEAA, 1'b0, 2, "mis_rd");
      wr(0, 32'h11, 32'h01020304, 4'hF, 2, 1'b0, "mis_wr");
      rdc(0, 32'h10, 32'h01020304, 1'b0, 2, "mis_aligned");
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
